adc_line_scanner: RTL and testbench

- Parametrised SPI master for the on-board ADC128S022 (8-ch, 12-bit). Scans a contiguous range of channels in order and publishes all results together at the end of each scan.
- Compares every channel result against a runtime threshold and produces one line-detect bit per channel.
- Sits between the ADC pins and the line-follower decision/PWM logic. It replaces the fixed three-channel, free-running ADC reader with a reset-able, handshaked, N-channel engine.

---
 rtl/adc_line_scanner_if.sv | 21 ++
 rtl/adc_line_scanner.sv | 250 +++++++++++++++++++++++++
 tb/tb_adc_line_scanner.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_line_scanner_if.sv
// SPI pin bundle between adc_line_scanner (master) and the ADC128S022 (slave).
interface adc_line_scanner_if;
  logic adc_cs_n;
  logic adc_sck;
  logic adc_din;
  logic adc_dout;

  modport master (
    output adc_cs_n,
    output adc_sck,
    output adc_din,
    input  adc_dout
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sck,
    input  adc_din,
    output adc_dout
  );
endinterface

// File: rtl/adc_line_scanner.sv
// ADC128S022 scanning SPI master: reads NUM_CH channels from CH_BASE, publishes all results plus
// per-channel line-detect bits at the end of each scan. Optional macro LINE_HYST_EN adds a hysteresis band.
module adc_line_scanner #(
  parameter int CLK_DIV = 10,
  parameter int NUM_CH  = 3,
  parameter int CH_BASE = 5,
  parameter int HYST    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [11:0]            threshold,
  adc_line_scanner_if.master     spi,
  output logic [12*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]      line_bits,
  output logic                   scan_done,
  output logic                   busy,
  output logic [2:0]             state_dbg
);

  // Status handshake: scan_done is a one-clk pulse on the clk where ch_data and line_bits
  // change; busy covers scan start through the last GAP and drops on that same clk.

  if (CLK_DIV < 2) begin : g_bad_div
    $error("adc_line_scanner: CLK_DIV must be >= 2");
  end
  if (NUM_CH < 1 || NUM_CH > 8 || CH_BASE < 0 || CH_BASE + NUM_CH - 1 > 7) begin : g_bad_ch
    $error("adc_line_scanner: channel range must lie within 0..7");
  end
  if (HYST < 0 || HYST > 4095) begin : g_bad_hyst
    $error("adc_line_scanner: HYST must be within 0..4095");
  end

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int FR_W  = 4;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [FR_W-1:0]  LAST_FR  = FR_W'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_FRAME    = 3'd2,
    S_GAP      = 3'd3,
    S_COMMIT   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic [FR_W-1:0]      frame_q, frame_d;
  logic [11:0]          shift_q, shift_d;
  logic [12*NUM_CH-1:0] shadow_q, shadow_d;
  logic [11:0]          thr_q, thr_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sck_q, sck_d;
  logic                 din_q, din_d;
  logic [12*NUM_CH-1:0] ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]    line_q, line_d;
  logic [NUM_CH-1:0]    line_next;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [2:0]           addr;

  // The last frame of a scan is a dummy that re-addresses CH_BASE to flush the ADC pipeline.
  always_comb begin
    addr = (frame_q == LAST_FR) ? 3'(CH_BASE) : 3'(CH_BASE) + frame_q[2:0];
  end

`ifdef LINE_HYST_EN
  logic [12:0] thr_sum;
  logic [11:0] thr_hi;
  logic [11:0] thr_lo;

  always_comb begin
    thr_sum   = {1'b0, thr_q} + 13'(HYST);
    thr_hi    = thr_sum[12] ? 12'hFFF : thr_sum[11:0];
    thr_lo    = (thr_q > 12'(HYST)) ? (thr_q - 12'(HYST)) : 12'h000;
    line_next = line_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (shadow_q[12*k +: 12] >= thr_hi) begin
        line_next[k] = 1'b1;
      end else if (shadow_q[12*k +: 12] < thr_lo) begin
        line_next[k] = 1'b0;
      end
    end
  end
`else
  always_comb begin
    line_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      line_next[k] = (shadow_q[12*k +: 12] >= thr_q);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    thr_d     = thr_q;
    ch_data_d = ch_data_q;
    line_d    = line_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          thr_d   = threshold;
          cnt_d   = '0;
          frame_d = '0;
          state_d = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = 4'd0;
          phase_d = 1'b0;
          state_d = S_FRAME;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FRAME: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            // Low phase ends: SCK rises on this clk, so this is the sample point.
            phase_d = 1'b1;
            if (bit_q >= 4'd4) begin
              shift_d = {shift_q[10:0], spi.adc_dout};
            end
          end else if (bit_q == 4'd15) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (frame_q == FR_W'(k + 1)) begin
                shadow_d[12*k +: 12] = shift_q;
              end
            end
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (frame_q == LAST_FR) begin
            ch_data_d = shadow_q;
            line_d    = line_next;
            done_d    = 1'b1;
            state_d   = S_COMMIT;
          end else begin
            frame_d = frame_q + FR_W'(1);
            state_d = S_CS_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_COMMIT: begin
        if (enable) begin
          thr_d   = threshold;
          cnt_d   = '0;
          frame_d = '0;
          state_d = S_CS_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin levels are registered from the next state so they line up with it and never glitch.
    cs_n_d = !(state_d == S_CS_SETUP || state_d == S_FRAME);
    sck_d  = !(state_d == S_FRAME && !phase_d);
    din_d  = 1'b0;
    if (state_d == S_FRAME) begin
      case (bit_d)
        4'd2:    din_d = addr[2];
        4'd3:    din_d = addr[1];
        4'd4:    din_d = addr[0];
        default: din_d = 1'b0;
      endcase
    end
    busy_d = (state_d == S_CS_SETUP) || (state_d == S_FRAME) || (state_d == S_GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      phase_q   <= 1'b0;
      frame_q   <= '0;
      shift_q   <= 12'h000;
      shadow_q  <= '0;
      thr_q     <= 12'h000;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b1;
      din_q     <= 1'b0;
      ch_data_q <= '0;
      line_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      frame_q   <= frame_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      thr_q     <= thr_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      din_q     <= din_d;
      ch_data_q <= ch_data_d;
      line_q    <= line_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign spi.adc_cs_n = cs_n_q;
  assign spi.adc_sck  = sck_q;
  assign spi.adc_din  = din_q;
  assign ch_data      = ch_data_q;
  assign line_bits    = line_q;
  assign scan_done    = done_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_adc_line_scanner.sv
// Directed bench for adc_line_scanner with a cycle-level ADC128S022 model on the SPI pins.
module tb_adc_line_scanner;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] threshold;
  logic [35:0] ch_data;
  logic [2:0]  line_bits;
  logic        scan_done;
  logic        busy;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  adc_line_scanner_if spi_if ();

  adc_line_scanner #(
    .CLK_DIV (10),
    .NUM_CH  (3),
    .CH_BASE (5),
    .HYST    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .threshold (threshold),
    .spi       (spi_if),
    .ch_data   (ch_data),
    .line_bits (line_bits),
    .scan_done (scan_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ADC model and pin monitor ----------------
  logic [11:0] mem [8];
  logic [15:0] word;
  logic [2:0]  cur_addr;
  logic [2:0]  prev_addr = 3'd0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b1;
  int          nfall = 0;
  int          cyc = 0;
  int          cs_len = 0;
  int          last_fall = -1;
  int          per_good = 0;
  int          per_bad = 0;
  int          sck_edges = 0;
  int          cs_low_total = 0;
  int          cs_len_q[$];
  logic [2:0]  addr_seen_q[$];
  logic [2:0]  exp_q[$];

  always @(negedge clk) begin
    if (cyc == 0) spi_if.adc_dout = 1'b0;
    if (prev_cs === 1'b1 && spi_if.adc_cs_n === 1'b0) begin
      word      = {4'h0, mem[prev_addr]};
      nfall     = 0;
      cur_addr  = 3'd0;
      cs_len    = 0;
      last_fall = -1;
    end
    if (spi_if.adc_cs_n === 1'b0) begin
      cs_len++;
      cs_low_total++;
    end
    if (prev_sck !== spi_if.adc_sck) sck_edges++;
    if (spi_if.adc_cs_n === 1'b0 && prev_sck === 1'b1 && spi_if.adc_sck === 1'b0) begin
      if (nfall < 16) spi_if.adc_dout = word[4'(15 - nfall)];
      nfall++;
      if (last_fall >= 0) begin
        if (cyc - last_fall == 20) per_good++;
        else per_bad++;
      end
      last_fall = cyc;
    end
    if (spi_if.adc_cs_n === 1'b0 && prev_sck === 1'b0 && spi_if.adc_sck === 1'b1 &&
        nfall >= 3 && nfall <= 5) begin
      cur_addr[2'(5 - nfall)] = spi_if.adc_din;
    end
    if (prev_cs === 1'b0 && spi_if.adc_cs_n === 1'b1) begin
      cs_len_q.push_back(cs_len);
      if (nfall >= 5) prev_addr = cur_addr;
      if (nfall == 16) addr_seen_q.push_back(cur_addr);
    end
    prev_cs  = spi_if.adc_cs_n;
    prev_sck = spi_if.adc_sck;
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) check("busy_start_timeout", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (scan_done) break;
    end
    if (!scan_done) check("scan_done_timeout", scan_done, 1);
  endtask

  // Starts one scan from IDLE and returns the scan length counted in clks (busy..scan_done).
  task automatic run_scan(input logic [11:0] d0, d1, d2, thr, output int len);
    int n;
    mem[5]    = d0;
    mem[6]    = d1;
    mem[7]    = d2;
    threshold = thr;
    enable    = 1'b1;
    @(negedge clk);
    wait_busy();
    enable = 1'b0;
    wait_done(n);
    len = n + 1;
  endtask

  typedef struct {
    logic [11:0] d0;
    logic [11:0] d1;
    logic [11:0] d2;
    logic [11:0] thr;
    logic [2:0]  exp_plain;
    logic [2:0]  exp_hyst;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int len;
    int edges0;
    int cslow0;
    logic [2:0] exp_line;

    // Hysteresis column assumes the line_bits history left by the preceding steps.
    vecs[0] = '{12'h000, 12'hFFF, 12'h800, 12'h800, 3'b110, 3'b110};
    vecs[1] = '{12'h410, 12'h000, 12'hFFF, 12'h400, 3'b101, 3'b100};
    vecs[2] = '{12'h421, 12'h000, 12'hFFF, 12'h400, 3'b101, 3'b101};
    vecs[3] = '{12'h3F0, 12'h000, 12'hFFF, 12'h400, 3'b100, 3'b101};
    vecs[4] = '{12'h3DF, 12'h000, 12'hFFF, 12'h400, 3'b100, 3'b100};
    vecs[5] = '{12'hFFE, 12'hFFF, 12'h001, 12'hFFF, 3'b010, 3'b010};
    vecs[6] = '{12'h000, 12'h7FF, 12'h123, 12'h000, 3'b111, 3'b110};

    for (int i = 0; i < 8; i++) mem[i] = 12'h000;

    // Reset state
    rst = 1'b1;
    enable = 1'b0;
    threshold = 12'h000;
    tick(3);
    check("rst_cs_n", spi_if.adc_cs_n, 1);
    check("rst_sck", spi_if.adc_sck, 1);
    check("rst_din", spi_if.adc_din, 0);
    check("rst_ch_data", ch_data, 0);
    check("rst_line_bits", line_bits, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick(2);

    // First scan, enable held high
    mem[5] = 12'h111;
    mem[6] = 12'h222;
    mem[7] = 12'h333;
    threshold = 12'h200;
    enable = 1'b1;
    @(negedge clk);
    wait_busy();
    wait_done(n);
    check("scan1_len", n + 1, 1401);
    check("scan1_ch_data", ch_data, 36'h333222111);
    check("scan1_line_bits", line_bits, 3'b110);
    check("scan1_busy_at_done", busy, 0);
    check("scan1_frames", cs_len_q.size(), 4);
    for (int j = 0; j < 4 && j < cs_len_q.size(); j++) check($sformatf("cs_low_len%0d", j), cs_len_q[j], 330);
    check("sck_period_bad", per_bad, 0);
    check("sck_period_cnt", per_good, 60);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd5);
    check("addr_count", addr_seen_q.size(), 4);
    while (exp_q.size() > 0 && addr_seen_q.size() > 0) check("frame_addr", addr_seen_q.pop_front(), exp_q.pop_front());

    // Back-to-back scan; threshold change mid-scan must not apply yet
    mem[5] = 12'h1FF;
    mem[6] = 12'h200;
    mem[7] = 12'hFFF;
    tick(50);
    threshold = 12'h000;
    wait_done(n);
    check("b2b_period", n + 50, 1401);
    check("scan2_ch_data", ch_data, 36'hFFF2001FF);
    check("scan2_line_bits", line_bits, 3'b110);

    // Scan 3 uses the new threshold; enable dropped during frame 1
    tick(400);
    enable = 1'b0;
    wait_done(n);
    check("scan3_len", n + 400, 1401);
    check("scan3_line_bits", line_bits, 3'b111);
    check("scan3_ch_data", ch_data, 36'hFFF2001FF);
    tick(1);
    check("scan3_pulse_width", scan_done, 0);
    check("scan3_busy_after", busy, 0);
    edges0 = sck_edges;
    cslow0 = cs_low_total;
    tick(200);
    check("idle_sck_edges", sck_edges - edges0, 0);
    check("idle_cs_low", cs_low_total - cslow0, 0);
    check("idle_busy", busy, 0);
    check("idle_hold_line", line_bits, 3'b111);

    // Table-driven scans from IDLE
    for (int i = 0; i < 7; i++) begin
`ifdef LINE_HYST_EN
      exp_line = vecs[i].exp_hyst;
`else
      exp_line = vecs[i].exp_plain;
`endif
      run_scan(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].thr, len);
      check($sformatf("vec%0d_len", i), len, 1401);
      check($sformatf("vec%0d_ch_data", i), ch_data, {vecs[i].d2, vecs[i].d1, vecs[i].d0});
      check($sformatf("vec%0d_line_bits", i), line_bits, exp_line);
      tick(3);
    end

    // Reset 500 clks into a scan
    mem[5] = 12'h777;
    enable = 1'b1;
    @(negedge clk);
    wait_busy();
    tick(499);
    rst = 1'b1;
    tick(1);
    check("midrst_cs_n", spi_if.adc_cs_n, 1);
    check("midrst_sck", spi_if.adc_sck, 1);
    check("midrst_din", spi_if.adc_din, 0);
    check("midrst_ch_data", ch_data, 0);
    check("midrst_line_bits", line_bits, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    rst = 1'b0;
    enable = 1'b0;
    tick(3);
    check("midrst_idle_cs_n", spi_if.adc_cs_n, 1);
    run_scan(12'hABC, 12'h5A5, 12'h0F0, 12'h100, len);
    check("post_rst_len", len, 1401);
    check("post_rst_ch_data", ch_data, 36'h0F05A5ABC);
    check("post_rst_line_bits", line_bits, 3'b011);
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
